tree_msg_endpoint: RTL and testbench

//  Inside-side consumer/producer for axi_fifo_dummy: pops inbound 64-bit msgs from in_fifo head, decodes,

---
 rtl/treeval_msg_pkg.sv | 61 ++++++
 rtl/tree_regfile.sv | 52 +++++
 rtl/tree_msg_endpoint.sv | 156 +++++++++++++++
 tb/tb_tree_msg_endpoint.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/treeval_msg_pkg.sv
// Message format shared by the tree endpoint and axi_fifo_dummy users:
// opcodes, field positions, packed message view and a response builder.
package treeval_msg_pkg;

  localparam int W_MSG = 64;

  localparam int OP_MSB   = 63;
  localparam int OP_LSB   = 60;
  localparam int SRC_MSB  = 59;
  localparam int SRC_LSB  = 52;
  localparam int DST_MSB  = 51;
  localparam int DST_LSB  = 44;
  localparam int ADDR_MSB = 43;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  typedef enum logic [3:0] {
    OP_WR     = 4'd1,
    OP_RD     = 4'd2,
    OP_RD_RSP = 4'd3,
    OP_WR_ACK = 4'd4
  } op_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [11:0] addr;
    logic [31:0] data;
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_EXEC,
    ST_RESP
  } state_e;

  // Only WR and RD are serviceable; responses arriving here are misrouted.
  function automatic logic op_is_request(input logic [3:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

  function automatic logic [W_MSG-1:0] build_msg(
    input op_e         op,
    input logic [7:0]  src,
    input logic [7:0]  dst,
    input logic [11:0] addr,
    input logic [31:0] data
  );
    msg_t m;
    m.op   = op;
    m.src  = src;
    m.dst  = dst;
    m.addr = addr;
    m.data = data;
    return m;
  endfunction

endpackage

// File: rtl/tree_regfile.sv
// DEPTH x 32 register file: per-entry write select where the local port wins
// over the network port on an address clash, plus two asynchronous reads.
module tree_regfile #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          net_we,
  input  logic [AW-1:0] net_addr,
  input  logic [31:0]   net_wdata,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [31:0]   loc_wdata,
  input  logic [AW-1:0] rd_a_addr,
  output logic [31:0]   rd_a_data,
  input  logic [AW-1:0] rd_b_addr,
  output logic [31:0]   rd_b_data
);

  logic [31:0] mem [DEPTH];

  // Each entry decides independently, so local and network writes to
  // different addresses in the same cycle both land.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [31:0] ent_q;
    logic [31:0] ent_d;

    always_comb begin
      ent_d = ent_q;
      if (loc_we && (loc_addr == AW'(gi))) begin
        ent_d = loc_wdata;
      end else if (net_we && (net_addr == AW'(gi))) begin
        ent_d = net_wdata;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign mem[gi] = ent_q;
  end

  assign rd_a_data = mem[rd_a_addr];
  assign rd_b_data = mem[rd_b_addr];

endmodule

// File: rtl/tree_msg_endpoint.sv
// Inside-side endpoint: pops inbound messages, services WR/RD against the
// local register file and pushes registered responses toward out_fifo.
module tree_msg_endpoint
  import treeval_msg_pkg::*;
#(
  parameter logic [7:0] NODE_ID = 8'h00,
  parameter int         DEPTH   = 16,
  parameter int         W_CNT   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_in_msg_rdy,
  input  logic [W_MSG-1:0]         i_in_msg,
  output logic                     i_in_msg_ack,
  output logic                     i_out_msg_rdy,
  output logic [W_MSG-1:0]         i_out_msg,
  input  logic                     i_out_msg_ack,
  input  logic                     loc_we,
  input  logic [$clog2(DEPTH)-1:0] loc_addr,
  input  logic [31:0]              loc_wdata,
  output logic [31:0]              loc_rdata,
  output logic [W_CNT-1:0]         cnt_rx,
  output logic [W_CNT-1:0]         cnt_drop,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [W_MSG-1:0] msg_q, msg_d;
  logic             in_ack_q, in_ack_d;
  logic             out_rdy_q, out_rdy_d;
  logic [W_MSG-1:0] out_msg_q, out_msg_d;
  logic [W_CNT-1:0] cnt_rx_q, cnt_rx_d;
  logic [W_CNT-1:0] cnt_drop_q, cnt_drop_d;

  logic [3:0]  m_op;
  logic [7:0]  m_src;
  logic [7:0]  m_dst;
  logic [11:0] m_addr;
  logic [31:0] m_data;
  logic [AW-1:0] m_idx;
  logic        m_drop;
  logic        net_we;
  logic [31:0] net_rdata;

  assign m_op   = msg_q[OP_MSB:OP_LSB];
  assign m_src  = msg_q[SRC_MSB:SRC_LSB];
  assign m_dst  = msg_q[DST_MSB:DST_LSB];
  assign m_addr = msg_q[ADDR_MSB:ADDR_LSB];
  assign m_data = msg_q[DATA_MSB:DATA_LSB];
  assign m_idx  = m_addr[AW-1:0];

  // Any address bit above the register-file index makes the request out of range.
  assign m_drop = (m_dst != NODE_ID) || !op_is_request(m_op) || ((m_addr >> AW) != 12'd0);

  tree_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .net_we    (net_we),
    .net_addr  (m_idx),
    .net_wdata (m_data),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .rd_a_addr (loc_addr),
    .rd_a_data (loc_rdata),
    .rd_b_addr (m_idx),
    .rd_b_data (net_rdata)
  );

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    in_ack_d   = 1'b0;
    out_rdy_d  = out_rdy_q;
    out_msg_d  = out_msg_q;
    cnt_rx_d   = cnt_rx_q;
    cnt_drop_d = cnt_drop_q;
    net_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_in_msg_rdy) begin
          msg_d    = i_in_msg;
          in_ack_d = 1'b1;
          state_d  = ST_POP;
        end
      end
      ST_POP: begin
        if (cnt_rx_q != '1) begin
          cnt_rx_d = cnt_rx_q + W_CNT'(1);
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (m_drop) begin
          if (cnt_drop_q != '1) begin
            cnt_drop_d = cnt_drop_q + W_CNT'(1);
          end
          state_d = ST_IDLE;
        end else begin
          // WR_ACK echoes the network data even if a local write overrides it.
          if (m_op == OP_WR) begin
            net_we    = 1'b1;
            out_msg_d = build_msg(OP_WR_ACK, NODE_ID, m_src, m_addr, m_data);
          end else begin
            out_msg_d = build_msg(OP_RD_RSP, NODE_ID, m_src, m_addr, net_rdata);
          end
          out_rdy_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_out_msg_ack) begin
          out_rdy_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      msg_q      <= '0;
      in_ack_q   <= 1'b0;
      out_rdy_q  <= 1'b0;
      out_msg_q  <= '0;
      cnt_rx_q   <= '0;
      cnt_drop_q <= '0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      in_ack_q   <= in_ack_d;
      out_rdy_q  <= out_rdy_d;
      out_msg_q  <= out_msg_d;
      cnt_rx_q   <= cnt_rx_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign i_in_msg_ack  = in_ack_q;
  assign i_out_msg_rdy = out_rdy_q;
  assign i_out_msg     = out_msg_q;
  assign cnt_rx        = cnt_rx_q;
  assign cnt_drop      = cnt_drop_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tree_msg_endpoint.sv
// Directed bench for tree_msg_endpoint (NODE_ID=5, DEPTH=16, 4-bit counters).
module tb_tree_msg_endpoint;

  localparam int W_CNT = 4;
  localparam int MAXC  = 15;

  logic        clk;
  logic        rst;
  logic        i_in_msg_rdy;
  logic [63:0] i_in_msg;
  logic        i_in_msg_ack;
  logic        i_out_msg_rdy;
  logic [63:0] i_out_msg;
  logic        i_out_msg_ack;
  logic        loc_we;
  logic [3:0]  loc_addr;
  logic [31:0] loc_wdata;
  logic [31:0] loc_rdata;
  logic [W_CNT-1:0] cnt_rx;
  logic [W_CNT-1:0] cnt_drop;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  int exp_rx   = 0;
  int exp_drop = 0;

  tree_msg_endpoint #(
    .NODE_ID (8'h05),
    .DEPTH   (16),
    .W_CNT   (W_CNT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_in_msg_rdy  (i_in_msg_rdy),
    .i_in_msg      (i_in_msg),
    .i_in_msg_ack  (i_in_msg_ack),
    .i_out_msg_rdy (i_out_msg_rdy),
    .i_out_msg     (i_out_msg),
    .i_out_msg_ack (i_out_msg_ack),
    .loc_we        (loc_we),
    .loc_addr      (loc_addr),
    .loc_wdata     (loc_wdata),
    .loc_rdata     (loc_rdata),
    .cnt_rx        (cnt_rx),
    .cnt_drop      (cnt_drop),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] msg;
    bit          resp;
    logic [63:0] exp_out;
    bit          lw;
    logic [3:0]  la;
    logic [31:0] ld;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vt[11];

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; optional local write lands in the EXEC cycle.
  task automatic run_txn(input int idx, input vec_t v);
    i_in_msg_rdy = 1'b1;
    i_in_msg     = v.msg;
    step();
    chk("pop_ack", 64'(i_in_msg_ack), 64'd1);
    chk("busy_pop", 64'(busy), 64'd1);
    i_in_msg_rdy = 1'b0;
    step();
    chk("ack_once", 64'(i_in_msg_ack), 64'd0);
    chk("rdy_exec", 64'(i_out_msg_rdy), 64'd0);
    loc_we    = v.lw;
    loc_addr  = v.la;
    loc_wdata = v.ld;
    step();
    loc_we = 1'b0;
    exp_rx++;
    if (v.resp) begin
      chk("resp_rdy", 64'(i_out_msg_rdy), 64'd1);
      chk("resp_msg", i_out_msg, v.exp_out);
      if (v.lw) chk("loc_reg", 64'(loc_rdata), 64'(v.exp_reg));
      i_out_msg_ack = 1'b1;
      step();
      i_out_msg_ack = 1'b0;
      chk("rdy_clear", 64'(i_out_msg_rdy), 64'd0);
    end else begin
      exp_drop++;
      chk("drop_rdy", 64'(i_out_msg_rdy), 64'd0);
    end
    chk("idle_busy", 64'(busy), 64'd0);
    chk("cnt_rx", 64'(cnt_rx), 64'(sat(exp_rx)));
    chk("cnt_drop", 64'(cnt_drop), 64'(sat(exp_drop)));
    $display("txn %0d in=%h resp=%0b out=%h rx=%0d drop=%0d", idx, v.msg, i_out_msg_rdy | v.resp,
             i_out_msg, cnt_rx, cnt_drop);
  endtask

  initial begin
    vec_t d;
    vt[0]  = '{64'h1020_5003_DEAD_BEEF, 1'b1, 64'h4050_2003_DEAD_BEEF, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[1]  = '{64'h2070_5003_0000_0000, 1'b1, 64'h3050_7003_DEAD_BEEF, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[2]  = '{64'h1020_9001_1111_1111, 1'b0, 64'd0, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[3]  = '{64'h6020_5001_2222_2222, 1'b0, 64'd0, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[4]  = '{64'h1020_5010_3333_3333, 1'b0, 64'd0, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[5]  = '{64'h3020_5001_4444_4444, 1'b0, 64'd0, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[6]  = '{64'h10A0_500F_1234_5678, 1'b1, 64'h4050_A00F_1234_5678, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[7]  = '{64'h2030_500F_0000_0000, 1'b1, 64'h3050_300F_1234_5678, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[8]  = '{64'h2010_5000_0000_0000, 1'b1, 64'h3050_1000_0000_0000, 1'b0, 4'd0, 32'd0, 32'd0};
    vt[9]  = '{64'h1020_5004_0000_0002, 1'b1, 64'h4050_2004_0000_0002, 1'b1, 4'd4, 32'd1, 32'd1};
    vt[10] = '{64'h2020_5004_0000_0000, 1'b1, 64'h3050_2004_0000_0001, 1'b1, 4'd4, 32'd7, 32'd7};

    rst           = 1'b0;
    i_in_msg_rdy  = 1'b0;
    i_in_msg      = '0;
    i_out_msg_ack = 1'b0;
    loc_we        = 1'b0;
    loc_addr      = '0;
    loc_wdata     = '0;
    #1;
    chk("rst_rdy", 64'(i_out_msg_rdy), 64'd0);
    chk("rst_ack", 64'(i_in_msg_ack), 64'd0);
    chk("rst_out", i_out_msg, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'({cnt_rx, cnt_drop}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    for (int i = 0; i < 11; i++) run_txn(i, vt[i]);

    loc_addr = 4'd3;
    #1 chk("loc_rd3", 64'(loc_rdata), 64'hDEAD_BEEF);
    loc_addr = 4'd15;
    #1 chk("loc_rd15", 64'(loc_rdata), 64'h1234_5678);

    // Back-pressure: out_fifo withholds ack for 20 cycles while another msg waits.
    i_in_msg_rdy = 1'b1;
    i_in_msg     = 64'h1020_5005_A5A5_A5A5;
    step();
    chk("hold_pop", 64'(i_in_msg_ack), 64'd1);
    i_in_msg = 64'h2020_5005_0000_0000;
    step();
    step();
    for (int c = 0; c < 20; c++) begin
      chk("hold_rdy", 64'(i_out_msg_rdy), 64'd1);
      chk("hold_msg", i_out_msg, 64'h4050_2005_A5A5_A5A5);
      chk("hold_noack", 64'(i_in_msg_ack), 64'd0);
      step();
    end
    i_out_msg_ack = 1'b1;
    step();
    i_out_msg_ack = 1'b0;
    chk("hold_release", 64'(i_out_msg_rdy), 64'd0);
    chk("hold_idle_ack", 64'(i_in_msg_ack), 64'd0);
    step();
    chk("next_pop", 64'(i_in_msg_ack), 64'd1);
    i_in_msg_rdy = 1'b0;
    step();
    step();
    chk("next_rdy", 64'(i_out_msg_rdy), 64'd1);
    chk("next_msg", i_out_msg, 64'h3050_2005_A5A5_A5A5);
    i_out_msg_ack = 1'b1;
    step();
    i_out_msg_ack = 1'b0;
    exp_rx += 2;
    $display("hold seq out=%h rx=%0d", i_out_msg, cnt_rx);

    // Push both counters past all-ones.
    d = '{64'h1020_9001_0000_0000, 1'b0, 64'd0, 1'b0, 4'd0, 32'd0, 32'd0};
    for (int i = 0; i < 12; i++) run_txn(100 + i, d);

    // Reset asserted while a response is pending.
    i_in_msg_rdy = 1'b1;
    i_in_msg     = 64'h1020_5006_0000_0099;
    step();
    i_in_msg_rdy = 1'b0;
    step();
    step();
    chk("pre_rst_rdy", 64'(i_out_msg_rdy), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rdy", 64'(i_out_msg_rdy), 64'd0);
    chk("async_out", i_out_msg, 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    loc_addr = 4'd3;
    #1 chk("async_reg", 64'(loc_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_rdy", 64'(i_out_msg_rdy), 64'd0);
    chk("post_cnt", 64'({cnt_rx, cnt_drop}), 64'd0);
    $display("reset seq busy=%0b rx=%0d drop=%0d", busy, cnt_rx, cnt_drop);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
